// File: rtl/disp_pkg.sv
// Shared types and sizing helpers for the dispatch credit controller.
package disp_pkg;

  typedef enum logic [1:0] {
    CS_RUN     = 2'd0,
    CS_FLUSH   = 2'd1,
    CS_HOLD    = 2'd2,
    CS_RECOVER = 2'd3
  } credit_state_t;

  localparam int DEF_MEMISQ_DEPTH = 16;
  localparam int DEF_INTISQ_DEPTH = 16;
  localparam int DEF_SQ_DEPTH     = 16;
  localparam int DEF_FLUSH_HOLD   = 2;

  // Width able to hold every value 0..depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a synchronous load.
// The next-count value is exported so registered status can be computed in one cycle.
module credit_counter
  import disp_pkg::*;
#(
  parameter int DEPTH = DEF_MEMISQ_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       count_en,
  input  logic                       dec,
  input  logic                       inc,
  input  logic                       load,
  input  logic [$clog2(DEPTH+1)-1:0] load_val,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic [$clog2(DEPTH+1)-1:0] nxt
);

  localparam int W = credit_w(DEPTH);
  localparam logic [W-1:0] FULL = W'(DEPTH);

  always_comb begin
    nxt = cnt;
    if (load) begin
      nxt = load_val;
    end else if (count_en) begin
      if (dec && !inc) begin
        nxt = (cnt == '0) ? '0 : cnt - 1'b1;
      end else if (inc && !dec) begin
        nxt = (cnt == FULL) ? FULL : cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= FULL;
    end else begin
      cnt <= nxt;
    end
  end

  // Consuming with no credit, or returning into a full pool, is a protocol error.
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(count_en && !load && dec && !inc && cnt == '0));
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(count_en && !load && inc && !dec && cnt == FULL));

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// Dispatch credit tracking for mem ISQ, int ISQ and store queue, with flush recovery FSM.
// Optional stall/flush performance counters are built when DISP_CREDIT_PERF_EN is defined.
//
//   state   | meaning
//   RUN     | normal credit accounting, allocation allowed where credits remain
//   FLUSH   | flush_valid asserted, allocation blocked, counters frozen
//   HOLD    | FLUSH_HOLD cycles of quiet after flush_valid falls
//   RECOVER | one cycle reloading credits (ISQs full, SQ from sq_free_after_flush)
module dispatch_credit_ctrl
  import disp_pkg::*;
#(
  parameter int MEMISQ_DEPTH = DEF_MEMISQ_DEPTH,
  parameter int INTISQ_DEPTH = DEF_INTISQ_DEPTH,
  parameter int SQ_DEPTH     = DEF_SQ_DEPTH,
  parameter int FLUSH_HOLD   = DEF_FLUSH_HOLD
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          memisq_enq,
  input  logic                          intisq_enq,
  input  logic                          sq_enq,
  input  logic                          memisq_issue,
  input  logic                          intisq_issue,
  input  logic                          sq_deq,
  input  logic [$clog2(SQ_DEPTH+1)-1:0] sq_free_after_flush,
  input  logic                          flush_valid,
  output logic                          iq_can_alloc0,
  output logic                          iq_can_alloc1,
  output logic                          sq_can_alloc,
`ifdef DISP_CREDIT_PERF_EN
  output logic [31:0]                   perf_memisq_stall,
  output logic [31:0]                   perf_intisq_stall,
  output logic [31:0]                   perf_sq_stall,
  output logic [31:0]                   perf_flush_cycles,
`endif
  output logic [1:0]                    credit_state
);

  localparam int MW = credit_w(MEMISQ_DEPTH);
  localparam int IW = credit_w(INTISQ_DEPTH);
  localparam int SW = credit_w(SQ_DEPTH);
  localparam int HW = credit_w(FLUSH_HOLD);

  localparam logic [1:0] S_RUN     = CS_RUN;
  localparam logic [1:0] S_FLUSH   = CS_FLUSH;
  localparam logic [1:0] S_HOLD    = CS_HOLD;
  localparam logic [1:0] S_RECOVER = CS_RECOVER;

  logic [1:0]    state, next_state;
  logic [HW-1:0] hold_cnt;
  logic          count_en, reload;
  logic [SW-1:0] sq_reload;
  logic [MW-1:0] memisq_cnt, memisq_nxt;
  logic [IW-1:0] intisq_cnt, intisq_nxt;
  logic [SW-1:0] sq_cnt, sq_nxt;

  always_comb begin
    next_state = state;
    case (state)
      S_RUN:     if (flush_valid) next_state = S_FLUSH;
      S_FLUSH:   if (!flush_valid) next_state = S_HOLD;
      S_HOLD: begin
        if (flush_valid)         next_state = S_FLUSH;
        else if (hold_cnt == '0) next_state = S_RECOVER;
      end
      S_RECOVER: next_state = flush_valid ? S_FLUSH : S_RUN;
      default:   next_state = S_RUN;
    endcase
  end

  // Strobes in the flush cycle itself are dropped along with everything after it.
  assign count_en  = (state == S_RUN) && !flush_valid;
  assign reload    = (state == S_RECOVER) && !flush_valid;
  assign sq_reload = (sq_free_after_flush > SW'(SQ_DEPTH)) ? SW'(SQ_DEPTH) : sq_free_after_flush;

  credit_counter #(.DEPTH(MEMISQ_DEPTH)) u_memisq (
    .clock    (clock),
    .reset_n  (reset_n),
    .count_en (count_en),
    .dec      (memisq_enq),
    .inc      (memisq_issue),
    .load     (reload),
    .load_val (MW'(MEMISQ_DEPTH)),
    .cnt      (memisq_cnt),
    .nxt      (memisq_nxt)
  );

  credit_counter #(.DEPTH(INTISQ_DEPTH)) u_intisq (
    .clock    (clock),
    .reset_n  (reset_n),
    .count_en (count_en),
    .dec      (intisq_enq),
    .inc      (intisq_issue),
    .load     (reload),
    .load_val (IW'(INTISQ_DEPTH)),
    .cnt      (intisq_cnt),
    .nxt      (intisq_nxt)
  );

  credit_counter #(.DEPTH(SQ_DEPTH)) u_sq (
    .clock    (clock),
    .reset_n  (reset_n),
    .count_en (count_en),
    .dec      (sq_enq),
    .inc      (sq_deq),
    .load     (reload),
    .load_val (sq_reload),
    .cnt      (sq_cnt),
    .nxt      (sq_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_RUN;
      hold_cnt      <= '0;
      iq_can_alloc0 <= 1'b1;
      iq_can_alloc1 <= 1'b1;
      sq_can_alloc  <= 1'b1;
    end else begin
      state <= next_state;
      if (state == S_FLUSH && !flush_valid) begin
        hold_cnt <= HW'(FLUSH_HOLD - 1);
      end else if (state == S_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      iq_can_alloc0 <= (memisq_nxt != '0) && (next_state == S_RUN);
      iq_can_alloc1 <= (intisq_nxt != '0) && (next_state == S_RUN);
      sq_can_alloc  <= (sq_nxt != '0) && (next_state == S_RUN);
    end
  end

  assign credit_state = state;

`ifdef DISP_CREDIT_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_memisq_stall <= '0;
      perf_intisq_stall <= '0;
      perf_sq_stall     <= '0;
      perf_flush_cycles <= '0;
    end else begin
      if (state == S_RUN) begin
        if (!iq_can_alloc0 && perf_memisq_stall != '1) perf_memisq_stall <= perf_memisq_stall + 1'b1;
        if (!iq_can_alloc1 && perf_intisq_stall != '1) perf_intisq_stall <= perf_intisq_stall + 1'b1;
        if (!sq_can_alloc && perf_sq_stall != '1)      perf_sq_stall     <= perf_sq_stall + 1'b1;
      end else if (perf_flush_cycles != '1) begin
        perf_flush_cycles <= perf_flush_cycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Randomized self-checking bench for dispatch_credit_ctrl against a cycle-level credit model.
module tb_dispatch_credit_ctrl;

  localparam int D  = 16;
  localparam int FH = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       flush_valid;
  logic [4:0] sfaf;
  bit         enq_v [3];
  bit         rel_v [3];
  logic       iq_can_alloc0, iq_can_alloc1, sq_can_alloc;
  logic [1:0] credit_state;
`ifdef DISP_CREDIT_PERF_EN
  logic [31:0] perf_memisq_stall, perf_intisq_stall, perf_sq_stall, perf_flush_cycles;
`endif

  always #5 clock = ~clock;

  dispatch_credit_ctrl dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .memisq_enq          (enq_v[0]),
    .intisq_enq          (enq_v[1]),
    .sq_enq              (enq_v[2]),
    .memisq_issue        (rel_v[0]),
    .intisq_issue        (rel_v[1]),
    .sq_deq              (rel_v[2]),
    .sq_free_after_flush (sfaf),
    .flush_valid         (flush_valid),
    .iq_can_alloc0       (iq_can_alloc0),
    .iq_can_alloc1       (iq_can_alloc1),
    .sq_can_alloc        (sq_can_alloc),
`ifdef DISP_CREDIT_PERF_EN
    .perf_memisq_stall   (perf_memisq_stall),
    .perf_intisq_stall   (perf_intisq_stall),
    .perf_sq_stall       (perf_sq_stall),
    .perf_flush_cycles   (perf_flush_cycles),
`endif
    .credit_state        (credit_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: free credits per queue, whether flush is held, and blocked cycles left after it falls.
  int m_cnt [3];
  int m_flush;
  int m_post;
`ifdef DISP_CREDIT_PERF_EN
  int unsigned m_perf [4];
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_run();
    return (m_flush == 0) && (m_post == 0);
  endfunction

  function automatic int m_state();
    if (m_flush != 0) return 1;
    if (m_post > 1)   return 2;
    if (m_post == 1)  return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_cnt[k] = D;
    m_flush = 0;
    m_post  = 0;
`ifdef DISP_CREDIT_PERF_EN
    for (int k = 0; k < 4; k++) m_perf[k] = 0;
`endif
  endtask

  task automatic model_update();
`ifdef DISP_CREDIT_PERF_EN
    if (m_run()) begin
      for (int k = 0; k < 3; k++) if (m_cnt[k] == 0) m_perf[k]++;
    end else begin
      m_perf[3]++;
    end
`endif
    if (m_run()) begin
      if (flush_valid) m_flush = 1;
      else for (int k = 0; k < 3; k++) m_cnt[k] = m_cnt[k] - int'(enq_v[k]) + int'(rel_v[k]);
    end else if (m_flush != 0) begin
      if (!flush_valid) begin
        m_flush = 0;
        m_post  = FH + 1;
      end
    end else if (flush_valid) begin
      m_flush = 1;
      m_post  = 0;
    end else begin
      m_post--;
      if (m_post == 0) begin
        m_cnt[0] = D;
        m_cnt[1] = D;
        m_cnt[2] = (int'(sfaf) > D) ? D : int'(sfaf);
      end
    end
  endtask

  task automatic compare_all();
    chk("can0", iq_can_alloc0, m_run() && m_cnt[0] > 0);
    chk("can1", iq_can_alloc1, m_run() && m_cnt[1] > 0);
    chk("can_sq", sq_can_alloc, m_run() && m_cnt[2] > 0);
    chk("state", credit_state, m_state());
    chk("memisq_cnt", dut.memisq_cnt, m_cnt[0]);
    chk("intisq_cnt", dut.intisq_cnt, m_cnt[1]);
    chk("sq_cnt", dut.sq_cnt, m_cnt[2]);
`ifdef DISP_CREDIT_PERF_EN
    chk("perf_mem", perf_memisq_stall, m_perf[0]);
    chk("perf_int", perf_intisq_stall, m_perf[1]);
    chk("perf_sq", perf_sq_stall, m_perf[2]);
    chk("perf_flush", perf_flush_cycles, m_perf[3]);
`endif
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare_all();
  endtask

  task automatic set_in(input bit e0, e1, e2, r0, r1, r2, input logic fv);
    enq_v[0] = e0; enq_v[1] = e1; enq_v[2] = e2;
    rel_v[0] = r0; rel_v[1] = r1; rel_v[2] = r2;
    flush_valid = fv;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_zero;
    int guard;
    int ep, rp;
    reset_n = 1'b0;
    sfaf    = '0;
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    model_reset();
    #12;
    compare_all();
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Drain mem ISQ: output falls right after the 16th enq.
    for (int i = 0; i < D; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 1'b0);
      step();
      if (i == D - 2) chk("mem_15th_can0", iq_can_alloc0, 1);
    end
    chk("mem_empty_can0", iq_can_alloc0, 0);
    chk("mem_empty_can1", iq_can_alloc1, 1);
    chk("mem_empty_cansq", sq_can_alloc, 1);

    set_in(0, 0, 0, 1, 0, 0, 1'b0);
    step();
    set_in(1, 0, 0, 1, 0, 0, 1'b0);
    step();
    chk("mem_enq_rel_cnt", dut.memisq_cnt, 1);
    chk("mem_enq_rel_can0", iq_can_alloc0, 1);

    for (int i = 0; i < D; i++) begin
      set_in(0, 1, 0, 0, 0, 0, 1'b0);
      step();
    end
    chk("int_empty_can1", iq_can_alloc1, 0);
    set_in(0, 0, 0, 0, 1, 0, 1'b0);
    step();
    chk("int_issue_can1", iq_can_alloc1, 1);

    // SQ exhausted, 3-cycle flush, reload with 5 surviving free entries.
    for (int i = 0; i < D; i++) begin
      set_in(0, 0, 1, 0, 0, 0, 1'b0);
      step();
    end
    chk("sq_empty_cansq", sq_can_alloc, 0);
    sfaf   = 5'd5;
    n_zero = 0;
    set_in(0, 0, 0, 0, 0, 0, 1'b1);
    repeat (3) begin
      step();
      if (!iq_can_alloc0 && !iq_can_alloc1 && !sq_can_alloc) n_zero++;
    end
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    guard = 0;
    while (!iq_can_alloc0 && guard < 20) begin
      step();
      guard++;
      if (!iq_can_alloc0 && !iq_can_alloc1 && !sq_can_alloc) n_zero++;
    end
    chk("flush_recover_bound", guard < 20, 1);
    chk("flush_blocked_cycles", n_zero, 6);
    chk("flush_mem_cnt", dut.memisq_cnt, 16);
    chk("flush_int_cnt", dut.intisq_cnt, 16);
    chk("flush_sq_cnt", dut.sq_cnt, 5);
    chk("flush_all_can", {iq_can_alloc0, iq_can_alloc1, sq_can_alloc}, 3'b111);

    // Re-flush during HOLD: no reload until the second flush completes.
    sfaf = 5'd9;
    set_in(0, 0, 0, 0, 0, 0, 1'b1); step();
    set_in(0, 0, 0, 0, 0, 0, 1'b0); step();
    chk("reflush_in_hold", credit_state, 2);
    set_in(0, 0, 0, 0, 0, 0, 1'b1); step();
    chk("reflush_state", credit_state, 1);
    set_in(0, 0, 0, 0, 0, 0, 1'b0);
    repeat (3) begin
      step();
      chk("reflush_no_reload", dut.sq_cnt, 5);
    end
    step();
    chk("reflush_sq_cnt", dut.sq_cnt, 9);
    chk("reflush_cansq", sq_can_alloc, 1);

    // Randomized legal traffic with occasional flushes.
    ep = 50; rp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        ep = $urandom_range(10, 90);
        rp = $urandom_range(10, 90);
      end
      if (m_run())           flush_valid = ($urandom_range(0, 99) < 2);
      else if (m_flush != 0) flush_valid = ($urandom_range(0, 99) < 70);
      else                   flush_valid = ($urandom_range(0, 99) < 8);
      for (int k = 0; k < 3; k++) begin
        enq_v[k] = (m_cnt[k] > 0) && ($urandom_range(0, 99) < ep);
        rel_v[k] = (m_cnt[k] < D) && ($urandom_range(0, 99) < rp);
      end
      sfaf = 5'($urandom_range(0, 31));
      step();
    end

    // Asynchronous reset while in HOLD.
    set_in(0, 0, 0, 0, 0, 0, 1'b1); step();
    set_in(0, 0, 0, 0, 0, 0, 1'b0); step();
    chk("rst_pre_hold", credit_state, 2);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clock);
    reset_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
